// File: rtl/ht16d35a_pkg.sv
// Shared types and the fixed power-on command table for the HT16D35A sequencer.
// Table bytes are stored byte 0 in the least significant position, matching wire order.
package ht16d35a_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_WAIT_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_READY
  } state_t;

  localparam int INIT_LEN    = 4;
  localparam int INIT_IDX_SZ = 2;
  localparam int INIT_BYTES  = 8;
  localparam int INIT_DLY_SZ = 20;

  typedef struct packed {
    logic [3:0]                  count;
    logic [INIT_BYTES-1:0][7:0]  bytes;
    logic [INIT_DLY_SZ-1:0]      post_delay;
  } init_entry_t;

  // E0 is the software reset; the driver needs a long settle before the next command.
  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{count: 4'd1, bytes: 64'h0000_0000_0000_00CC, post_delay: 20'd50000},
    '{count: 4'd2, bytes: 64'h0000_0000_0000_0135, post_delay: 20'd0},
    '{count: 4'd2, bytes: 64'h0000_0000_0000_0331, post_delay: 20'd0},
    '{count: 4'd2, bytes: 64'h0000_0000_0000_00C0, post_delay: 20'd0}
  };

endpackage

// File: rtl/ht16d35a_init_rom.sv
// Combinational lookup of one init table entry by index; no state, zero latency.
module ht16d35a_init_rom
  import ht16d35a_pkg::*;
(
  input  logic [INIT_IDX_SZ-1:0]  idx_i,
  output logic [3:0]              count_o,
  output logic [8*INIT_BYTES-1:0] data_o,
  output logic [INIT_DLY_SZ-1:0]  delay_o
);

  init_entry_t entry;

  always_comb begin
    entry   = INIT_TABLE[idx_i];
    count_o = entry.count;
    data_o  = entry.bytes;
    delay_o = entry.post_delay;
  end

endmodule

// File: rtl/ht16d35a_sequencer.sv
// Owns the HT16D35A SPI controller: power-up wait, init table replay, then host writes.
// Host request accepted in S_READY reaches spi_activate one cycle later when the controller is idle.
module ht16d35a_sequencer
  import ht16d35a_pkg::*;
#(
  parameter int NUM_SELECTS  = 2,
  parameter int OUT_BYTES    = 8,
  parameter int OUT_BYTES_SZ = $clog2(OUT_BYTES + 1),
  parameter int CLK_POWERUP  = 500000,
  parameter int ACT_TIMEOUT  = 64,
  parameter int DLY_SZ       = $clog2(CLK_POWERUP + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     spi_busy,
  output logic                     spi_activate,
  output logic [NUM_SELECTS-1:0]   spi_cs,
  output logic [8*OUT_BYTES-1:0]   spi_data,
  output logic [OUT_BYTES_SZ-1:0]  spi_count,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NUM_SELECTS-1:0]   req_cs,
  input  logic [8*OUT_BYTES-1:0]   req_data,
  input  logic [OUT_BYTES_SZ-1:0]  req_count,
  output logic                     init_done,
  output logic                     spi_err
);

  // The delay counter also carries table post-delays, which may exceed the power-up count.
  localparam int CNT_W  = (DLY_SZ > INIT_DLY_SZ) ? DLY_SZ : INIT_DLY_SZ;
  localparam int TO_SZ  = $clog2(ACT_TIMEOUT + 1);
  localparam int DATA_W = 8 * OUT_BYTES;

  localparam logic [CNT_W-1:0]        POWERUP_DLY = CNT_W'(CLK_POWERUP);
  localparam logic [CNT_W-1:0]        DLY_ONE     = CNT_W'(1);
  localparam logic [TO_SZ-1:0]        TO_LAST     = TO_SZ'(ACT_TIMEOUT - 1);
  localparam logic [TO_SZ-1:0]        TO_ONE      = TO_SZ'(1);
  localparam logic [OUT_BYTES_SZ-1:0] MAX_COUNT   = OUT_BYTES_SZ'(OUT_BYTES);
  localparam logic [INIT_IDX_SZ-1:0]  LAST_IDX    = INIT_IDX_SZ'(INIT_LEN - 1);
  localparam logic [INIT_IDX_SZ-1:0]  IDX_ONE     = INIT_IDX_SZ'(1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         dly_q, dly_d;
  logic [INIT_IDX_SZ-1:0]   idx_q, idx_d;
  logic                     from_host_q, from_host_d;
  logic [TO_SZ-1:0]         to_q, to_d;
  logic [NUM_SELECTS-1:0]   host_cs_q, host_cs_d;
  logic [DATA_W-1:0]        host_data_q, host_data_d;
  logic [OUT_BYTES_SZ-1:0]  host_count_q, host_count_d;
  logic                     act_q, act_d;
  logic [NUM_SELECTS-1:0]   cs_q, cs_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [OUT_BYTES_SZ-1:0]  count_q, count_d;
  logic                     init_done_q, init_done_d;
  logic                     err_q, err_d;

  logic [3:0]               rom_count;
  logic [8*INIT_BYTES-1:0]  rom_data;
  logic [INIT_DLY_SZ-1:0]   rom_delay;

  ht16d35a_init_rom u_init_rom (
    .idx_i   (idx_q),
    .count_o (rom_count),
    .data_o  (rom_data),
    .delay_o (rom_delay)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_POWERUP;
      dly_q        <= POWERUP_DLY;
      idx_q        <= '0;
      from_host_q  <= 1'b0;
      to_q         <= '0;
      host_cs_q    <= '0;
      host_data_q  <= '0;
      host_count_q <= '0;
      act_q        <= 1'b0;
      cs_q         <= '0;
      data_q       <= '0;
      count_q      <= '0;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      idx_q        <= idx_d;
      from_host_q  <= from_host_d;
      to_q         <= to_d;
      host_cs_q    <= host_cs_d;
      host_data_q  <= host_data_d;
      host_count_q <= host_count_d;
      act_q        <= act_d;
      cs_q         <= cs_d;
      data_q       <= data_d;
      count_q      <= count_d;
      init_done_q  <= init_done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    idx_d        = idx_q;
    from_host_d  = from_host_q;
    to_d         = to_q;
    host_cs_d    = host_cs_q;
    host_data_d  = host_data_q;
    host_count_d = host_count_q;
    act_d        = act_q;
    cs_d         = cs_q;
    data_d       = data_q;
    count_d      = count_q;
    init_done_d  = init_done_q;
    err_d        = err_q;

    unique case (state_q)
      S_POWERUP: begin
        if (dly_q <= DLY_ONE) begin
          dly_d       = '0;
          from_host_d = 1'b0;
          state_d     = S_WAIT_IDLE;
        end else begin
          dly_d = dly_q - DLY_ONE;
        end
      end

      S_WAIT_IDLE: begin
        // Operands only ever load here, on the cycle activate rises.
        if (!spi_busy) begin
          act_d   = 1'b1;
          to_d    = '0;
          state_d = S_ISSUE;
          if (from_host_q) begin
            cs_d    = host_cs_q;
            data_d  = host_data_q;
            count_d = host_count_q;
          end else begin
            cs_d    = '1;
            data_d  = DATA_W'(rom_data);
            count_d = OUT_BYTES_SZ'(rom_count);
          end
        end
      end

      S_ISSUE: begin
        if (spi_busy) begin
          act_d   = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          err_d   = 1'b1;
          act_d   = 1'b0;
          state_d = S_WAIT_IDLE;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end

      S_WAIT_DONE: begin
        if (!spi_busy) begin
          dly_d   = from_host_q ? '0 : CNT_W'(rom_delay);
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        if (dly_q != '0) begin
          dly_d = dly_q - DLY_ONE;
        end else if (from_host_q) begin
          state_d = S_READY;
        end else if (idx_q == LAST_IDX) begin
          init_done_d = 1'b1;
          state_d     = S_READY;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_WAIT_IDLE;
        end
      end

      S_READY: begin
        // Empty masks or zero counts are consumed here; the controller would never go busy.
        if (req_valid && (req_cs != '0) && (req_count != '0)) begin
          host_cs_d    = req_cs;
          host_data_d  = req_data;
          host_count_d = (req_count > MAX_COUNT) ? MAX_COUNT : req_count;
          from_host_d  = 1'b1;
          state_d      = S_WAIT_IDLE;
        end
      end

      default: state_d = S_POWERUP;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    if (state_q == S_READY) req_ready = 1'b1;
  end

  assign spi_activate = act_q;
  assign spi_cs       = cs_q;
  assign spi_data     = data_q;
  assign spi_count    = count_q;
  assign init_done    = init_done_q;
  assign spi_err      = err_q;

endmodule

// File: tb/tb_ht16d35a_sequencer.sv
// Directed bench: two sequencers on one clock, each driven by a small controller model.
// Instance A runs the main flow; instance B parks in E2 busy for the mid-transaction reset.
module tb_ht16d35a_sequencer;

  localparam int BUSY_LEN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        busy_a, busy_b;
  logic        act_a, act_b;
  logic [1:0]  cs_a, cs_b;
  logic [63:0] data_a, data_b;
  logic [3:0]  count_a, count_b;
  logic        req_valid_a, req_ready_a, req_ready_b;
  logic [1:0]  req_cs_a;
  logic [63:0] req_data_a;
  logic [3:0]  req_count_a;
  logic        init_a, init_b, err_a, err_b;

  int mode [2];
  int stick_at [2];
  int n_chk = 0;
  int n_pass = 0;

  ht16d35a_sequencer #(.CLK_POWERUP(100)) u_dut (
    .clk(clk), .reset(rst_a), .spi_busy(busy_a), .spi_activate(act_a), .spi_cs(cs_a),
    .spi_data(data_a), .spi_count(count_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_cs(req_cs_a), .req_data(req_data_a), .req_count(req_count_a),
    .init_done(init_a), .spi_err(err_a)
  );

  ht16d35a_sequencer #(.CLK_POWERUP(100)) u_dut_b (
    .clk(clk), .reset(rst_b), .spi_busy(busy_b), .spi_activate(act_b), .spi_cs(cs_b),
    .spi_data(data_b), .spi_count(count_b), .req_valid(1'b0), .req_ready(req_ready_b),
    .req_cs(2'b00), .req_data(64'h0), .req_count(4'h0),
    .init_done(init_b), .spi_err(err_b)
  );

  // Controller model: busy in reset, goes busy two cycles after activate, idle after BUSY_LEN.
  for (genvar g = 0; g < 2; g++) begin : g_stub
    logic busy, rst_g, act_g;
    int hold, lat, acc;
    assign rst_g = (g == 0) ? rst_a : rst_b;
    assign act_g = (g == 0) ? act_a : act_b;
    always @(posedge clk) begin
      if (rst_g) begin
        busy <= 1'b1; hold <= 0; lat <= 0; acc <= 0;
      end else if (mode[g] == 1) begin
        busy <= 1'b0; lat <= 0;
      end else if (mode[g] == 2) begin
        busy <= 1'b1; lat <= 0;
      end else if (!busy) begin
        if (act_g) begin
          if (lat == 1) begin busy <= 1'b1; hold <= BUSY_LEN; lat <= 0; acc <= acc + 1; end
          else lat <= lat + 1;
        end else lat <= 0;
      end else if (hold == 0) begin
        if (!(stick_at[g] != 0 && acc == stick_at[g])) busy <= 1'b0;
      end else hold <= hold - 1;
    end
  end
  assign busy_a = g_stub[0].busy;
  assign busy_b = g_stub[1].busy;

  int cyc = 0, n_act = 0, stab_err = 0;
  logic prev_act = 1'b0, prev_busy = 1'b0;
  logic [1:0]  h_cs;
  logic [63:0] h_data;
  logic [3:0]  h_count;
  logic [1:0]  act_cs [$];
  logic [63:0] act_data [$];
  logic [3:0]  act_count [$];
  int act_cyc [$];
  int fall_cyc [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_act <= act_a;
    prev_busy <= busy_a;
    if (act_a && !prev_act) begin
      n_act <= n_act + 1;
      act_cs.push_back(cs_a); act_data.push_back(data_a); act_count.push_back(count_a);
      act_cyc.push_back(cyc);
      h_cs <= cs_a; h_data <= data_a; h_count <= count_a;
    end else if (act_a && prev_act && (cs_a !== h_cs || data_a !== h_data || count_a !== h_count)) begin
      stab_err <= stab_err + 1;
    end
    if (!busy_a && prev_busy && n_act > 0) fall_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] n, input logic [63:0] d);
    req_valid_a = 1'b1; req_cs_a = c; req_count_a = n; req_data_a = d;
  endtask

  task automatic test_reset();
    n_chk++; if (act_a !== 1'b0) $display("FAIL reset_act got %0b want 0", act_a); else n_pass++;
    n_chk++; if (cs_a !== 2'b00) $display("FAIL reset_cs got %b want 00", cs_a); else n_pass++;
    n_chk++; if (data_a !== 64'h0) $display("FAIL reset_data got %h want 0", data_a); else n_pass++;
    n_chk++; if (count_a !== 4'h0) $display("FAIL reset_count got %0d want 0", count_a); else n_pass++;
    n_chk++; if (req_ready_a !== 1'b0) $display("FAIL reset_ready got %0b want 0", req_ready_a); else n_pass++;
    n_chk++; if (init_a !== 1'b0) $display("FAIL reset_init got %0b want 0", init_a); else n_pass++;
    n_chk++; if (err_a !== 1'b0) $display("FAIL reset_err got %0b want 0", err_a); else n_pass++;
  endtask

  task automatic test_powerup();
    int n;
    rst_a = 1'b0; rst_b = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (act_a) begin n = i; break; end
    end
    n_chk++; if (n != 101) $display("FAIL powerup_first_act got cycle %0d want 101", n); else n_pass++;
    n_chk++; if (cs_a !== 2'b11) $display("FAIL powerup_cs got %b want 11", cs_a); else n_pass++;
    n_chk++; if (data_a[7:0] !== 8'hCC) $display("FAIL powerup_byte0 got %h want cc", data_a[7:0]); else n_pass++;
    n_chk++; if (count_a !== 4'd1) $display("FAIL powerup_count got %0d want 1", count_a); else n_pass++;
  endtask

  task automatic test_init();
    logic [63:0] exp_d [4];
    logic [3:0]  exp_c [4];
    bit seen;
    int gap;
    exp_d = '{64'h00CC, 64'h0135, 64'h0331, 64'h00C0};
    exp_c = '{4'd1, 4'd2, 4'd2, 4'd2};
    seen = 1'b0;
    for (int i = 0; i < 60000; i++) begin
      if (init_a) begin seen = 1'b1; break; end
      step();
    end
    n_chk++; if (!seen) $display("FAIL init_done_timeout got 0 want 1"); else n_pass++;
    n_chk++; if (n_act != 4) $display("FAIL init_num_tx got %0d want 4", n_act); else n_pass++;
    for (int i = 0; i < 4 && i < n_act; i++) begin
      n_chk++;
      if (act_data[i] !== exp_d[i] || act_count[i] !== exp_c[i] || act_cs[i] !== 2'b11)
        $display("FAIL init_entry%0d got cs=%b cnt=%0d data=%h want cs=11 cnt=%0d data=%h",
                 i, act_cs[i], act_count[i], act_data[i], exp_c[i], exp_d[i]);
      else n_pass++;
    end
    gap = (n_act > 1 && fall_cyc.size() > 0) ? act_cyc[1] - fall_cyc[0] : 0;
    n_chk++; if (gap < 50000 || gap > 50010) $display("FAIL init_e0_gap got %0d want 50000..50010", gap); else n_pass++;
    step();
    n_chk++; if (req_ready_a !== 1'b1) $display("FAIL init_ready_after got %0b want 1", req_ready_a); else n_pass++;
    n_chk++; if (err_a !== 1'b0) $display("FAIL init_err got %0b want 0", err_a); else n_pass++;
  endtask

  task automatic test_host();
    int base;
    bit seen;
    base = n_act;
    send(2'b01, 4'd3, 64'h0000_0000_0034_12A0);
    n_chk++; if (req_ready_a !== 1'b1) $display("FAIL host_ready_pre got %0b want 1", req_ready_a); else n_pass++;
    step();
    req_valid_a = 1'b0;
    n_chk++; if (req_ready_a !== 1'b0 || act_a !== 1'b0) $display("FAIL host_accept got rdy=%0b act=%0b want 0 0", req_ready_a, act_a); else n_pass++;
    step();
    n_chk++; if (act_a !== 1'b1) $display("FAIL host_act_latency got %0b want 1", act_a); else n_pass++;
    n_chk++; if (cs_a !== 2'b01 || count_a !== 4'd3 || data_a !== 64'h0034_12A0)
      $display("FAIL host_operands got cs=%b cnt=%0d data=%h want 01 3 00000000003412a0", cs_a, count_a, data_a); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin step(); if (req_ready_a) begin seen = 1'b1; break; end end
    n_chk++; if (!seen) $display("FAIL host_ready_return got 0 want 1"); else n_pass++;
    n_chk++; if (n_act != base + 1) $display("FAIL host_num_tx got %0d want %0d", n_act, base + 1); else n_pass++;
    n_chk++; if (stab_err != 0) $display("FAIL host_stable got %0d changes want 0", stab_err); else n_pass++;
  endtask

  task automatic test_degenerate();
    logic [1:0] vc [2];
    logic [3:0] vn [2];
    int base;
    vc = '{2'b01, 2'b00};
    vn = '{4'd0, 4'd3};
    for (int v = 0; v < 2; v++) begin
      base = n_act;
      send(vc[v], vn[v], 64'h0000_0000_00AB_CDEF);
      n_chk++; if (req_ready_a !== 1'b1) $display("FAIL degen%0d_ready got %0b want 1", v, req_ready_a); else n_pass++;
      step();
      req_valid_a = 1'b0;
      repeat (10) step();
      n_chk++; if (n_act != base || req_ready_a !== 1'b1)
        $display("FAIL degen%0d_dropped got act_rises=%0d rdy=%0b want 0 1", v, n_act - base, req_ready_a); else n_pass++;
    end
  endtask

  task automatic test_oversize();
    bit seen;
    send(2'b10, 4'd12, 64'h8877_6655_4433_2211);
    step();
    req_valid_a = 1'b0;
    step();
    n_chk++; if (act_a !== 1'b1 || count_a !== 4'd8 || cs_a !== 2'b10)
      $display("FAIL oversize_clamp got act=%0b cnt=%0d cs=%b want 1 8 10", act_a, count_a, cs_a); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin step(); if (req_ready_a) begin seen = 1'b1; break; end end
    n_chk++; if (!seen) $display("FAIL oversize_ready_return got 0 want 1"); else n_pass++;
  endtask

  task automatic test_timeout();
    bit seen;
    mode[0] = 1;
    send(2'b01, 4'd1, 64'h55);
    step();
    req_valid_a = 1'b0;
    step();
    n_chk++; if (act_a !== 1'b1 || err_a !== 1'b0) $display("FAIL timeout_start got act=%0b err=%0b want 1 0", act_a, err_a); else n_pass++;
    repeat (63) step();
    n_chk++; if (act_a !== 1'b1 || err_a !== 1'b0) $display("FAIL timeout_hold63 got act=%0b err=%0b want 1 0", act_a, err_a); else n_pass++;
    step();
    n_chk++; if (act_a !== 1'b0 || err_a !== 1'b1) $display("FAIL timeout_fire got act=%0b err=%0b want 0 1", act_a, err_a); else n_pass++;
    step();
    n_chk++; if (act_a !== 1'b1 || data_a !== 64'h55 || count_a !== 4'd1)
      $display("FAIL timeout_retry got act=%0b data=%h cnt=%0d want 1 55 1", act_a, data_a, count_a); else n_pass++;
    mode[0] = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin step(); if (req_ready_a) begin seen = 1'b1; break; end end
    n_chk++; if (!seen || err_a !== 1'b1) $display("FAIL timeout_recover got rdy=%0b err=%0b want 1 1", seen, err_a); else n_pass++;
  endtask

  task automatic test_stuck_busy();
    int base;
    bit seen;
    mode[0] = 2;
    step();
    base = n_act;
    send(2'b01, 4'd2, 64'h1234);
    step();
    req_valid_a = 1'b0;
    repeat (50) step();
    n_chk++; if (n_act != base || act_a !== 1'b0 || req_ready_a !== 1'b0)
      $display("FAIL stuck_busy_wait got rises=%0d act=%0b rdy=%0b want 0 0 0", n_act - base, act_a, req_ready_a); else n_pass++;
    mode[0] = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin step(); if (req_ready_a) begin seen = 1'b1; break; end end
    n_chk++; if (!seen || n_act != base + 1) $display("FAIL stuck_busy_release got rdy=%0b rises=%0d want 1 1", seen, n_act - base); else n_pass++;
  endtask

  task automatic test_midreset();
    bit seen;
    int n;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (g_stub[1].acc == 3 && busy_b && !act_b) begin seen = 1'b1; break; end
      step();
    end
    n_chk++; if (!seen || data_b[15:0] !== 16'h0331 || init_b !== 1'b0)
      $display("FAIL midrst_in_e2 got found=%0b data=%h init=%0b want 1 0331 0", seen, data_b[15:0], init_b); else n_pass++;
    rst_b = 1'b1;
    step();
    n_chk++; if (act_b !== 1'b0 || cs_b !== 2'b00 || data_b !== 64'h0 || count_b !== 4'h0)
      $display("FAIL midrst_operands got act=%0b cs=%b data=%h cnt=%0d want all 0", act_b, cs_b, data_b, count_b); else n_pass++;
    n_chk++; if (req_ready_b !== 1'b0 || init_b !== 1'b0 || err_b !== 1'b0)
      $display("FAIL midrst_status got rdy=%0b init=%0b err=%0b want 0 0 0", req_ready_b, init_b, err_b); else n_pass++;
    rst_b = 1'b0;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (act_b) begin n = i; break; end
    end
    n_chk++; if (n != 101) $display("FAIL midrst_restart_cycle got %0d want 101", n); else n_pass++;
    n_chk++; if (data_b[7:0] !== 8'hCC || count_b !== 4'd1 || cs_b !== 2'b11 || init_b !== 1'b0)
      $display("FAIL midrst_restart_e0 got b0=%h cnt=%0d cs=%b init=%0b want cc 1 11 0", data_b[7:0], count_b, cs_b, init_b); else n_pass++;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_valid_a = 1'b0; req_cs_a = 2'b00; req_data_a = 64'h0; req_count_a = 4'h0;
    mode[0] = 0; mode[1] = 0;
    stick_at[0] = 0; stick_at[1] = 3;
    repeat (3) step();
    test_reset();
    test_powerup();
    test_init();
    test_host();
    test_degenerate();
    test_oversize();
    test_timeout();
    test_stuck_busy();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
